// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives the ROM address, registers the returned instruction and
// handles stall, branch redirect and halt for a simple IDLE/RUN/DONE program controller.
module fetch_seq #(
    parameter int unsigned D = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    output logic [D-1:0] prog_ctr_out,
    input  logic [8:0]   mach_code,
    output logic [8:0]   instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [D-1:0] branch_target,
    input  logic         halt,
    output logic         done,
    output logic [15:0]  cycle_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q;
    logic [D-1:0]   pc_q;
    logic [D-1:0]   instr_pc_q;
    logic [8:0]     instr_q;
    logic           valid_q;
    logic           done_q;
    logic [15:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        pc_q    <= start_addr;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    // Control inputs only qualify a live instruction; a bubble always fetches.
                    if (valid_q && halt) begin
                        state_q <= StDone;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (valid_q && stall) begin
                        valid_q <= 1'b1;
                    end else if (valid_q && branch_taken) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                    end else begin
                        instr_q    <= mach_code;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_q + D'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr_out = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = valid_q;
    assign done         = done_q;
    assign cycle_cnt    = cnt_q;

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter D, default 12, is the program-counter width; ROM depth is 2**D words.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin execution; honoured only in IDLE or DONE.
REQ-005 start_addr  input  D  first fetch address, sampled in the start cycle.
REQ-006 prog_ctr_out  output  D  address to instruction ROM; equals the PC register.
REQ-007 mach_code  input  9  combinational ROM data for prog_ctr_out.
REQ-008 instr  output  9  registered instruction presented to decode.
REQ-009 instr_pc  output  D  address that instr was fetched from.
REQ-010 instr_valid  output  1  instr is a live instruction to execute this cycle.
REQ-011 stall  input  1  datapath hold request.
REQ-012 branch_taken  input  1  datapath redirect for the current valid instr.
REQ-013 branch_target  input  D  absolute redirect address.
REQ-014 halt  input  1  current valid instr is the program terminator.
REQ-015 done  output  1  program finished; high in DONE.
REQ-016 cycle_cnt  output  16  RUN-state cycle count, saturating.

Function
REQ-017 States SHALL be IDLE, RUN, DONE, encoded in a state register.
REQ-018 IDLE: PC, instr, instr_pc held; instr_valid=0; done=0; start=1 -> PC<=start_addr, cycle_cnt<=0, next state RUN.
REQ-019 RUN cycle without stall/branch/halt: instr<=mach_code, instr_pc<=PC, instr_valid<=1, PC<=PC+1 mod 2**D.
REQ-020 Fetch latency SHALL be one cycle: instruction at address A appears on instr the cycle after prog_ctr_out=A.
REQ-021 First RUN cycle after start SHALL have instr_valid=0 (pipeline fill); branch_taken/halt/stall are ignored while instr_valid=0.
REQ-022 stall=1 with instr_valid=1: PC, instr, instr_pc, instr_valid all held; branch_taken ignored.
REQ-023 branch_taken=1 with instr_valid=1 and stall=0: PC<=branch_target, instr_valid<=0 next cycle (sequential fetch squashed); target instruction valid one cycle later.
REQ-024 halt=1 with instr_valid=1 SHALL take priority over stall and branch_taken: next state DONE, instr_valid<=0, PC held.
REQ-025 Priority in RUN: halt > stall > branch_taken > sequential.
REQ-026 PC increment SHALL wrap 2**D-1 -> 0 with no flag.
REQ-027 DONE: done=1, instr_valid=0, PC/instr/instr_pc held; start=1 restarts exactly as in IDLE and done<=0 next cycle.
REQ-028 start in RUN SHALL be ignored.
REQ-029 cycle_cnt increments every RUN cycle including stalled and bubble cycles, saturates at 16'hFFFF, holds in IDLE/DONE, clears only on accepted start or reset.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, done=0, cycle_cnt=0, regardless of clk.
REQ-031 Reset asserted mid-RUN SHALL abandon the program; no instr_valid pulse after release until a new start.
REQ-032 Release of rst_n SHALL not by itself begin fetching.

Verification
REQ-033 start, start_addr=5, ROM[5..7]=A,B,C -> prog_ctr_out 5,6,7; instr_valid 0 then 1; instr A,B,C with instr_pc 5,6,7 on consecutive cycles.
REQ-034 branch_taken=1, branch_target=0x40 while instr_pc=6 -> next cycle instr_valid=0, prog_ctr_out=0x40; following cycle instr=ROM[0x40], instr_pc=0x40.
REQ-035 stall=1 for 3 cycles while instr_pc=9 -> instr/instr_pc/prog_ctr_out unchanged 3 cycles, cycle_cnt advances by 3; branch_taken asserted during stall has no effect.
REQ-036 start_addr=0xFFE, no branches -> prog_ctr_out 0xFFE,0xFFF,0x000,0x001.
REQ-037 halt=1 with stall=1 and branch_taken=1 -> DONE next cycle, done=1, instr_valid=0; later start with start_addr=3 -> done=0, fetch resumes at 3, cycle_cnt restarts from 0.
REQ-038 rst_n pulsed low between clock edges mid-RUN -> all outputs zero immediately; no fetch until start.
